// File: rtl/cache_line_refill.sv
// cache_line_refill: accepts one read miss, bursts the line from memory into the cache array
// and forwards the missed word to the requester the cycle after it arrives.
module cache_line_refill #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TAG_WIDTH     = 18,
    parameter int SET_WIDTH     = 8,
    parameter int OFFSET_WIDTH  = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      miss_valid,
    input  logic [ADDRESS_WIDTH-1:0]  miss_addr,
    output logic                      miss_ready,
    output logic                      mem_req,
    output logic [ADDRESS_WIDTH-1:0]  mem_addr,
    input  logic                      mem_gnt,
    input  logic                      mem_rvalid,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      fill_we,
    output logic [SET_WIDTH-1:0]      fill_set,
    output logic [TAG_WIDTH-1:0]      fill_tag,
    output logic [OFFSET_WIDTH-3:0]   fill_word,
    output logic [DATA_WIDTH-1:0]     fill_data,
    output logic                      fill_done,
    output logic                      data_ready,
    output logic [DATA_WIDTH-1:0]     data_out
);
    localparam int WORD_WIDTH = OFFSET_WIDTH - 2;

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t                      state_q, state_d;
    logic [ADDRESS_WIDTH-1:2]    addr_q, addr_d;
    logic [WORD_WIDTH-1:0]       cnt_q, cnt_d;
    logic                        miss_ready_q, miss_ready_d;
    logic                        mem_req_q, mem_req_d;
    logic                        fill_we_q, fill_we_d;
    logic [WORD_WIDTH-1:0]       fill_word_q, fill_word_d;
    logic [DATA_WIDTH-1:0]       fill_data_q, fill_data_d;
    logic                        fill_done_q, fill_done_d;
    logic                        data_ready_q, data_ready_d;
    logic [DATA_WIDTH-1:0]       data_out_q, data_out_d;
    logic [WORD_WIDTH-1:0]       crit_word;
    logic                        unused_byte_sel;

    // byte-within-word bits never matter for a word-granular refill
    assign unused_byte_sel = ^miss_addr[1:0];
    assign crit_word  = addr_q[OFFSET_WIDTH-1:2];
    assign miss_ready = miss_ready_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = {addr_q[ADDRESS_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
    assign fill_set   = addr_q[OFFSET_WIDTH+SET_WIDTH-1:OFFSET_WIDTH];
    assign fill_tag   = addr_q[ADDRESS_WIDTH-1:ADDRESS_WIDTH-TAG_WIDTH];
    assign fill_we    = fill_we_q;
    assign fill_word  = fill_word_q;
    assign fill_data  = fill_data_q;
    assign fill_done  = fill_done_q;
    assign data_ready = data_ready_q;
    assign data_out   = data_out_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        fill_word_d  = fill_word_q;
        fill_data_d  = fill_data_q;
        data_out_d   = data_out_q;
        fill_we_d    = 1'b0;
        fill_done_d  = 1'b0;
        data_ready_d = 1'b0;
        case (state_q)
            IDLE: if (miss_valid && miss_ready_q) begin
                state_d = REQ;
                addr_d  = miss_addr[ADDRESS_WIDTH-1:2];
                cnt_d   = '0;
            end
            REQ: state_d = mem_gnt ? FILL : REQ;
            FILL: if (mem_rvalid) begin
                fill_we_d    = 1'b1;
                fill_word_d  = cnt_q;
                fill_data_d  = mem_rdata;
                cnt_d        = cnt_q + WORD_WIDTH'(1);
                data_ready_d = cnt_q == crit_word;
                data_out_d   = (cnt_q == crit_word) ? mem_rdata : data_out_q;
                fill_done_d  = &cnt_q;
                state_d      = (&cnt_q) ? DONE : FILL;
            end
            default: state_d = IDLE;
        endcase
        mem_req_d    = state_d == REQ;
        miss_ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cnt_q        <= '0;
            miss_ready_q <= 1'b0;
            mem_req_q    <= 1'b0;
            fill_we_q    <= 1'b0;
            fill_word_q  <= '0;
            fill_data_q  <= '0;
            fill_done_q  <= 1'b0;
            data_ready_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            miss_ready_q <= miss_ready_d;
            mem_req_q    <= mem_req_d;
            fill_we_q    <= fill_we_d;
            fill_word_q  <= fill_word_d;
            fill_data_q  <= fill_data_d;
            fill_done_q  <= fill_done_d;
            data_ready_q <= data_ready_d;
            data_out_q   <= data_out_d;
        end
    end
endmodule

// File: tb/tb_cache_line_refill.sv
// tb_cache_line_refill: directed and randomized line refills checked against a transaction-level
// model of expected beats, fill writes, critical-word forwarding and handshakes.
module tb_cache_line_refill;
    logic        clk = 1'b0, rst = 1'b1;
    logic        miss_valid = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] miss_addr = '0, mem_rdata = '0;
    logic        miss_ready, mem_req, fill_we, fill_done, data_ready;
    logic [31:0] mem_addr, fill_data, data_out;
    logic [7:0]  fill_set;
    logic [17:0] fill_tag;
    logic [3:0]  fill_word;

    int passed = 0, failed = 0, total = 0;
    int req_cycles, we_count;
    logic [31:0] beats [16];

    cache_line_refill dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_we(fill_we), .fill_set(fill_set), .fill_tag(fill_tag),
        .fill_word(fill_word), .fill_data(fill_data), .fill_done(fill_done),
        .data_ready(data_ready), .data_out(data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {miss_ready, mem_req, fill_we, fill_done, data_ready, fill_word, fill_set, fill_tag}, 64'd0);
        chk({tag, "_addr_data"}, {mem_addr, fill_data}, 64'd0);
        chk({tag, "_data_out"}, data_out, 64'd0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (miss_ready !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", miss_ready, 1);
    endtask

    // gap_mode: 0 back-to-back, 1 idle cycle between beats, 2 random gaps
    task automatic run_miss(input logic [31:0] addr, input int gnt_delay, input int gap_mode,
                            input bit use_a0, input bit busy, input int stop_at);
        logic [31:0] line;
        logic [3:0]  crit;
        int          sent;
        bit          v, pv;
        line = addr & ~32'h3F;
        crit = addr[5:2];
        for (int i = 0; i < 16; i++) beats[i] = use_a0 ? 32'hA0 + i : $urandom;
        wait_ready();
        miss_valid = 1'b1;
        miss_addr  = addr;
        @(negedge clk);
        miss_valid = busy;
        miss_addr  = busy ? $urandom : addr;
        req_cycles = 0;
        for (int d = 0; d <= gnt_delay; d++) begin
            if (mem_req === 1'b1) req_cycles++;
            chk("req_addr", mem_addr, line);
            chk("req_no_we", fill_we, 0);
            chk("req_ready", miss_ready, 0);
            mem_gnt    = (d == gnt_delay);
            mem_rvalid = busy && ($urandom_range(0, 1) == 1);
            mem_rdata  = $urandom;
            @(negedge clk);
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk("gnt_req_drop", mem_req, 0);
        chk("spurious_req_we", fill_we, 0);
        sent = 0; pv = 0; we_count = 0;
        while (sent < stop_at) begin
            v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? !pv : ($urandom_range(0, 2) != 0);
            mem_rvalid = v;
            mem_rdata  = v ? beats[sent] : $urandom;
            if (busy) begin
                miss_valid = 1'b1;
                miss_addr  = $urandom;
            end
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (fill_we === 1'b1) we_count++;
            chk("fill_we", fill_we, v);
            chk("data_ready", data_ready, v && sent == crit);
            chk("fill_done", fill_done, v && sent == 15);
            chk("busy_ready", miss_ready, 0);
            if (v) begin
                chk("fill_word", fill_word, sent);
                chk("fill_data", fill_data, beats[sent]);
                chk("fill_set", fill_set, addr[13:6]);
                chk("fill_tag", fill_tag, addr[31:14]);
                if (sent == crit) chk("fwd_data", data_out, beats[crit]);
                sent++;
            end
            pv = v;
        end
        miss_valid = 1'b0;
        if (stop_at == 16) begin
            chk("we_count", we_count, 16);
            @(negedge clk);
            chk("ready_after", miss_ready, 1);
            chk("we_after", fill_we, 0);
            chk("done_after", fill_done, 0);
            chk("dr_after", data_ready, 0);
            chk("data_out_hold", data_out, beats[crit]);
        end
    endtask

    initial begin
        #1;
        chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_post_reset", miss_ready, 1);
        // spurious beats in IDLE
        repeat (3) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            @(negedge clk);
            chk("idle_spur_we", fill_we, 0);
            chk("idle_spur_req", mem_req, 0);
        end
        mem_rvalid = 1'b0;

        run_miss(32'h0001_2354, 0, 0, 1'b1, 1'b0, 16);
        chk("a0_crit", data_out, 32'hA5);
        chk("a0_req_cycles", req_cycles, 1);

        run_miss({$urandom} & 32'hFFFF_FFFF, 4, 1, 1'b0, 1'b0, 16);
        chk("gap_req_cycles", req_cycles, 5);

        run_miss(({$urandom} & ~32'h3C) | 32'h3C, 2, 0, 1'b0, 1'b0, 16);

        run_miss($urandom, 3, 2, 1'b0, 1'b1, 16);

        // reset mid-fill after 7 beats
        run_miss($urandom, 1, 0, 1'b0, 1'b0, 7);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (9) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            @(negedge clk);
            chk("post_rst_we", fill_we, 0);
            chk("post_rst_done", fill_done, 0);
            chk("post_rst_dr", data_ready, 0);
        end
        mem_rvalid = 1'b0;
        run_miss($urandom, 0, 0, 1'b0, 1'b0, 16);

        for (int t = 0; t < 6; t++)
            run_miss($urandom, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, $urandom_range(0, 1) == 1, 16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cache_line_refill.md
# cache_line_refill

Miss-handling stage directly upstream of the set-associative cache array. It accepts one read-miss address at a time and issues a line-burst request to backing memory. Returned beats are written into the cache array one word per cycle, with the set and tag the array needs. The missed word is forwarded to the requester as soon as it arrives (critical-word forwarding), so the requester does not wait for the whole line.

## Interface
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width (4 bytes)
- TAG_WIDTH, 18, tag field = addr[31:14]
- SET_WIDTH, 8, set field = addr[13:6]
- OFFSET_WIDTH, 6, byte offset in line; words per line WORDS = 2^(OFFSET_WIDTH-2) = 16; word index = addr[5:2]

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- miss_valid  in  1  miss request present
- miss_addr  in  ADDRESS_WIDTH  missed byte address
- miss_ready  out  1  block can accept a miss (IDLE only)
- mem_req  out  1  burst request to memory
- mem_addr  out  ADDRESS_WIDTH  line-aligned address: low OFFSET_WIDTH bits are 0
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  one returned beat on mem_rdata
- mem_rdata  in  DATA_WIDTH  beat data, in ascending word order 0..WORDS-1
- fill_we  out  1  write one word into cache array
- fill_set  out  SET_WIDTH  target set
- fill_tag  out  TAG_WIDTH  tag to install
- fill_word  out  OFFSET_WIDTH-2  word index of current write
- fill_data  out  DATA_WIDTH  word to write
- fill_done  out  1  line complete; the array sets VALID for the line
- data_ready  out  1  one-cycle pulse: requested word on data_out
- data_out  out  DATA_WIDTH  forwarded critical word; holds last value otherwise

## Operation
- States: IDLE, REQ, FILL, DONE. Reset puts the block in IDLE.
- Reset values: every output is 0, the beat counter is 0, and latched address registers are 0.
- IDLE
  - miss_ready=1.
  - On miss_valid, latch miss_addr and go to REQ.
  - mem_rvalid is ignored.
- REQ
  - mem_req=1, with mem_addr = {latched[31:6], 6'b0}.
  - Hold both until mem_gnt=1, then go to FILL.
  - mem_rvalid in REQ is ignored; memory never returns a beat before the cycle after gnt.
- FILL: each mem_rvalid beat is registered.
  - Next cycle: fill_we=1, fill_word=beat counter value, fill_data=beat.
  - The counter increments by 1.
  - When the counter equals the latched word index, data_ready=1 and data_out=beat, in the same cycle as that fill_we.
  - Gaps between beats are allowed; the counter only advances on mem_rvalid.
- After the 16th beat is sampled (counter == WORDS-1 and mem_rvalid), go to DONE.
- DONE (one cycle)
  - The final fill_we is presented with fill_done=1.
  - Next state is IDLE.
- fill_set and fill_tag come from the latched address and are stable from REQ through DONE.
- miss_ready=0 in REQ, FILL and DONE. miss_valid in those states is not latched; the requester holds it.
- Beat counter: OFFSET_WIDTH-2 bits, cleared on entry to REQ. Wrap after the last beat does not matter because the state leaves FILL.
- Reset mid-operation (any state) aborts:
  - no fill_done, fill_we=0, data_ready=0.
  - Beats arriving after reset are ignored in IDLE.

## Timing
- Miss handshake at edge 0 → REQ and mem_req=1 in cycle 1.
- mem_gnt sampled at edge k → FILL from cycle k+1, mem_req=0.
- mem_rvalid sampled at edge e → fill_we/data pulse in cycle e+1 (1-cycle latency).
- Best case with back-to-back beats, miss at edge 0, gnt at edge 1:
  - beats at edges 2..17
  - fill_we in cycles 3..18
  - fill_done in cycle 18
  - miss_ready=1 in cycle 19
- A new miss can be accepted in the first IDLE cycle after DONE.
- fill_we is never high in two different lines' contexts without an intervening IDLE cycle.

## Test plan
- Basic critical-word forward
  - Stimulus: miss 0x0001_2354 (tag 0x00004, set 0x8D, word 5), gnt immediately, 16 consecutive beats 0xA0..0xAF.
  - Required: mem_addr=0x0001_2340; fill_word 0..15 with data A0..AF; data_ready only with word 5, data_out=0xA5; fill_done with word 15.
- Gapped beats and delayed grant
  - Stimulus: gnt after 4 cycles; one idle cycle between every beat.
  - Required: mem_req is held 5 cycles with mem_addr stable; exactly 16 fill_we pulses; no write on idle cycles.
- Last-word miss
  - Stimulus: miss addr[5:2]=15.
  - Required: data_ready, the final fill_we and fill_done all in the same cycle; miss_ready=1 the next cycle.
- Busy and spurious inputs
  - Stimulus: miss_valid asserted during FILL; mem_rvalid pulses in IDLE and REQ.
  - Required: miss_ready=0 and address unchanged; no fill_we or counter movement from the spurious beats.
- Reset mid-fill
  - Stimulus: assert rst after 7 beats, then deliver the remaining 9 beats.
  - Required: outputs go to 0 immediately (asynchronously); no fill_done; the remaining beats produce no fill_we; the next miss fills normally from word 0.
